uarttospi_camp2: RTL and testbench

- Return-path block: turns the UART receiver byte stream into two 12-bit setpoints for the downstream SPI DAC writer.
- Hunts for a 5-byte command frame and checks an XOR checksum.
- Valid frame: latches both channel values and issues a one-cycle start to the SPI writer, honouring its busy handshake.
- Bad or stalled frames are dropped and counted.

---
 rtl/uarttospi_camp2_if.sv | 26 ++
 rtl/uarttospi_camp2.sv | 119 +++++++++++
 tb/tb_uarttospi_camp2.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uarttospi_camp2_if.sv
// Byte-stream in / SPI-writer setpoint out bundle for uarttospi_camp2.
// slave is the converter's view, master is the view of whatever drives it.
interface uarttospi_camp2_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 12;

    logic                RxD_data_ready;
    logic [BYTE_W-1:0]   RxD_data;
    logic                busy;
    logic [DATA_W-1:0]   data1;
    logic [DATA_W-1:0]   data2;
    logic                start;
    logic                frame_err;
    logic                overrun;
    logic [BYTE_W-1:0]   err_cnt;

    modport slave (
        input  RxD_data_ready, RxD_data, busy,
        output data1, data2, start, frame_err, overrun, err_cnt
    );

    modport master (
        output RxD_data_ready, RxD_data, busy,
        input  data1, data2, start, frame_err, overrun, err_cnt
    );
endinterface

// File: rtl/uarttospi_camp2.sv
// Parses 5-byte checksummed UART frames into two 12-bit DAC setpoints and
// hands them to the SPI writer with a busy-aware one-cycle start pulse.
module uarttospi_camp2 #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    uarttospi_camp2_if.slave   bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 12;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [BYTE_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        GOT_H  = 3'd1,
        GOT_B0 = 3'd2,
        GOT_B1 = 3'd3,
        GOT_B2 = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BYTE_W-1:0]   r_b0;
    logic [BYTE_W-1:0]   r_b1;
    logic [BYTE_W-1:0]   r_b2;
    logic                r_pending;
    logic [DATA_W-1:0]   r_data1;
    logic [DATA_W-1:0]   r_data2;
    logic                r_start;
    logic                r_frame_err;
    logic                r_overrun;
    logic [BYTE_W-1:0]   r_err_cnt;

    logic w_strobe;
    logic w_at_chk;
    logic w_chk_ok;
    logic w_valid;
    logic w_timeout;
    logic w_err;

    assign w_strobe  = bus.RxD_data_ready;
    assign w_at_chk  = w_strobe && (r_state == GOT_B2);
    assign w_chk_ok  = (bus.RxD_data == (r_b0 ^ r_b1 ^ r_b2));
    assign w_valid   = w_at_chk && w_chk_ok;
    // A strobe in the timeout cycle wins, so timeout requires no strobe.
    assign w_timeout = !w_strobe && (r_state != HUNT) && (r_cnt == TO_LAST);
    assign w_err     = (w_at_chk && !w_chk_ok) || w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_pending   <= 1'b0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_start     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= w_err;

            if (w_strobe) begin
                r_cnt <= '0;
                case (r_state)
                    HUNT:    if (bus.RxD_data == HEADER) r_state <= GOT_H;
                    GOT_H:   begin r_b0 <= bus.RxD_data; r_state <= GOT_B0; end
                    GOT_B0:  begin r_b1 <= bus.RxD_data; r_state <= GOT_B1; end
                    GOT_B1:  begin r_b2 <= bus.RxD_data; r_state <= GOT_B2; end
                    GOT_B2:  r_state <= HUNT;
                    default: r_state <= HUNT;
                endcase
            end else if (r_state == HUNT) begin
                r_cnt <= '0;
            end else if (w_timeout) begin
                r_cnt   <= '0;
                r_state <= HUNT;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_err && (r_err_cnt != ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + BYTE_W'(1);
            end

            // A start just issued counts as busy so start never repeats back-to-back.
            if (w_valid) begin
                r_data1 <= {r_b0, r_b1[7:4]};
                r_data2 <= {r_b1[3:0], r_b2};
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else if (bus.busy || r_start) begin
                    r_pending <= 1'b1;
                end else begin
                    r_start <= 1'b1;
                end
            end else if (r_pending && !bus.busy && !r_start) begin
                r_start   <= 1'b1;
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.data1     = r_data1;
    assign bus.data2     = r_data2;
    assign bus.start     = r_start;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_uarttospi_camp2.sv
// Directed and random frames against a byte-level frame model of uarttospi_camp2.
module tb_uarttospi_camp2;
    localparam int unsigned TO  = 200;
    localparam logic [7:0]  HDR = 8'hA5;

    logic clk;
    logic rst;
    uarttospi_camp2_if bus();

    uarttospi_camp2 #(.HEADER(HDR), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor: cumulative counts of observed output pulses.
    int          mon_start = 0;
    int          mon_ferr  = 0;
    int          mon_ovr   = 0;
    int          mon_b2b   = 0;
    logic        prev_start = 1'b0;
    logic [11:0] mon_ld1 = '0;
    logic [11:0] mon_ld2 = '0;

    always @(negedge clk) begin
        if (bus.start) begin
            mon_start = mon_start + 1;
            mon_ld1   = bus.data1;
            mon_ld2   = bus.data2;
            if (prev_start) mon_b2b = mon_b2b + 1;
        end
        prev_start = bus.start;
        if (bus.frame_err) mon_ferr = mon_ferr + 1;
        if (bus.overrun)   mon_ovr  = mon_ovr + 1;
    end

    // Reference model: frame-level view of the byte stream.
    logic [7:0]  mq[$];
    logic        m_busy    = 1'b0;
    logic        m_pending = 1'b0;
    logic [11:0] m_d1 = '0;
    logic [11:0] m_d2 = '0;
    logic [7:0]  m_err = '0;
    int          e_start = 0;
    int          e_ferr  = 0;
    int          e_ovr   = 0;
    logic [11:0] e_ld1 = '0;
    logic [11:0] e_ld2 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_error();
        e_ferr++;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        if (mq.size() == 0) begin
            if (b == HDR) mq.push_back(b);
        end else begin
            mq.push_back(b);
            if (mq.size() == 5) begin
                if ((mq[1] ^ mq[2] ^ mq[3]) == mq[4]) begin
                    m_d1 = (12'(mq[1]) << 4) | 12'(mq[2] >> 4);
                    m_d2 = (12'(mq[2] & 8'h0F) << 8) | 12'(mq[3]);
                    if (m_pending) e_ovr++;
                    else if (m_busy) m_pending = 1'b1;
                    else begin
                        e_start++;
                        e_ld1 = m_d1;
                        e_ld2 = m_d2;
                    end
                end else begin
                    mdl_error();
                end
                mq.delete();
            end
        end
    endtask

    task automatic mdl_timeout();
        if (mq.size() > 0) begin
            mq.delete();
            mdl_error();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.RxD_data_ready = 1'b1;
        bus.RxD_data       = b;
        @(negedge clk);
        bus.RxD_data_ready = 1'b0;
        mdl_byte(b);
        idle(gap);
    endtask

    task automatic send_frame(input logic [11:0] c1, input logic [11:0] c2,
                              input logic [7:0] corrupt, input int gap);
        logic [7:0] b0, b1, b2;
        b0 = c1[11:4];
        b1 = {c1[3:0], c2[11:8]};
        b2 = c2[7:0];
        send_byte(HDR, gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b0 ^ b1 ^ b2 ^ corrupt, 0);
    endtask

    task automatic set_busy(input logic v);
        bus.busy = v;
        m_busy   = v;
        @(negedge clk);
        if (!v && m_pending) begin
            m_pending = 1'b0;
            e_start++;
            e_ld1 = m_d1;
            e_ld2 = m_d2;
        end
    endtask

    task automatic compare_all(input string tag);
        idle(3);
        #1;
        check({tag, ".starts"},  32'(mon_start), 32'(e_start));
        check({tag, ".ferr"},    32'(mon_ferr),  32'(e_ferr));
        check({tag, ".ovr"},     32'(mon_ovr),   32'(e_ovr));
        check({tag, ".data1"},   32'(bus.data1), 32'(m_d1));
        check({tag, ".data2"},   32'(bus.data2), 32'(m_d2));
        check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
        check({tag, ".b2b"},     32'(mon_b2b),   32'd0);
        if (e_start > 0) begin
            check({tag, ".sent1"}, 32'(mon_ld1), 32'(e_ld1));
            check({tag, ".sent2"}, 32'(mon_ld2), 32'(e_ld2));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data1"},   32'(bus.data1),     32'd0);
        check({tag, ".data2"},   32'(bus.data2),     32'd0);
        check({tag, ".start"},   32'(bus.start),     32'd0);
        check({tag, ".ferr"},    32'(bus.frame_err), 32'd0);
        check({tag, ".ovr"},     32'(bus.overrun),   32'd0);
        check({tag, ".err_cnt"}, 32'(bus.err_cnt),   32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.RxD_data_ready = 1'b0;
        bus.RxD_data = '0;
        bus.busy = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);

        // 1: valid frame, start one cycle after CHK strobe
        send_byte(8'hA5, 10);
        send_byte(8'h12, 10);
        send_byte(8'h34, 10);
        send_byte(8'h56, 10);
        send_byte(8'h70, 0);
        check("t1.start_lat", 32'(bus.start), 32'd1);
        check("t1.data1",     32'(bus.data1), 32'h123);
        check("t1.data2",     32'(bus.data2), 32'h456);
        @(negedge clk);
        check("t1.start_once", 32'(bus.start), 32'd0);
        compare_all("t1");

        // 2: bad checksum, then a good frame
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        send_byte(8'h34, 2);
        send_byte(8'h56, 2);
        send_byte(8'h71, 0);
        check("t2.ferr_pulse", 32'(bus.frame_err), 32'd1);
        check("t2.no_start",   32'(bus.start),     32'd0);
        compare_all("t2");
        send_frame(12'h321, 12'h654, 8'h00, 1);
        compare_all("t2b");

        // 3: busy hold
        set_busy(1'b1);
        send_frame(12'hABC, 12'hDEF, 8'h00, 1);
        idle(20);
        compare_all("t3.held");
        set_busy(1'b0);
        check("t3.start_rel", 32'(bus.start), 32'd1);
        check("t3.data1",     32'(bus.data1), 32'hABC);
        check("t3.data2",     32'(bus.data2), 32'hDEF);
        compare_all("t3");

        // 4: overrun while pending
        set_busy(1'b1);
        send_frame(12'h123, 12'h456, 8'h00, 1);
        send_frame(12'hABC, 12'hDEF, 8'h00, 1);
        check("t4.ovr_pulse", 32'(bus.overrun), 32'd1);
        idle(5);
        set_busy(1'b0);
        compare_all("t4");

        // 5: garbage in HUNT, long-but-legal gap, then a timeout
        send_byte(8'h00, 3);
        send_byte(8'h5A, 3);
        compare_all("t5.garbage");
        send_byte(HDR, TO - 3);
        send_byte(8'h11, TO - 3);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33, 0);
        compare_all("t5.slow");
        send_byte(HDR, 0);
        send_byte(8'h12, 0);
        idle(TO - 5);
        check("t5.early", 32'(mon_ferr), 32'(e_ferr));
        idle(10);
        mdl_timeout();
        compare_all("t5.to");
        send_frame(12'h0F0, 12'hF0F, 8'h00, 0);
        compare_all("t5.after");

        // Random frames: busy, corruption, garbage, HEADER-valued payload
        for (int it = 0; it < 60; it++) begin
            logic [11:0] c1, c2;
            logic [7:0]  cor;
            c1  = 12'($urandom);
            c2  = 12'($urandom);
            cor = ($urandom_range(0, 4) == 0) ? 8'(($urandom % 255) + 1) : 8'h00;
            if ($urandom_range(0, 3) == 0) send_byte(8'h00 | 8'($urandom_range(0, 8'hA4)), 1);
            if ($urandom_range(0, 2) == 0) set_busy(1'b1);
            send_frame(c1, c2, cor, $urandom_range(0, 4));
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) set_busy(1'b0);
        end
        set_busy(1'b0);
        compare_all("rand");

        // 6: reset mid-frame
        send_byte(8'hA5, 1);
        send_byte(8'h12, 1);
        rst = 1'b0;
        idle(2);
        #1;
        check_reset_outputs("t6.rst");
        rst = 1'b1;
        mq.delete();
        m_pending = 1'b0;
        m_d1 = '0;
        m_d2 = '0;
        m_err = '0;
        idle(1);
        send_byte(8'h34, 2);
        send_byte(8'h56, 2);
        send_byte(8'h70, 2);
        compare_all("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
